// File: rtl/prng_pkg.sv
// Shared definitions for the shared xorshift32 random source.
//   prng_state_e : controller FSM states (IDLE -> STEP -> OUT)
//   DEF_*        : default seed, shift amounts and output modulus
//   xorshift32() : one generator step, 32-bit truncating arithmetic
package prng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_OUT  = 2'd2
  } prng_state_e;

  localparam logic [31:0] DEF_SEED  = 32'hDEAD_BEEF;
  localparam int unsigned DEF_A     = 13;
  localparam int unsigned DEF_B     = 17;
  localparam int unsigned DEF_C     = 5;
  localparam logic [31:0] DEF_RANGE = 32'h0004_0001;
  localparam logic [31:0] DEF_MIN   = 32'h0000_0000;

  // x ^= x >> a; x ^= x << b; x ^= x >> c
  // Each step is an invertible linear map, so a nonzero input never
  // produces zero.
  function automatic logic [31:0] xorshift32(input logic [31:0] x,
                                             input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
    logic [31:0] y;
    y = x ^ (x >> a);
    y = y ^ (y << b);
    y = y ^ (y >> c);
    return y;
  endfunction

endpackage

// File: rtl/prng_rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   ptr     : index with highest priority this round
//   winner  : first requesting index found from ptr upward, wrapping
//   any_req : at least one request bit is set (winner is valid)
module prng_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_req
);

  logic [PTR_W-1:0] sel;
  logic             found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // offset i from the pointer, wrapped into 0..NUM_REQ-1
      sel = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[sel]) begin
        winner = sel;
        found  = 1'b1;
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/prng_share_ctrl.sv
// Sequencing and sharing controller for a clocked xorshift32 generator.
// Serves NUM_REQ requesters round-robin; each served request advances the
// generator once and returns one range-reduced word.
//
// Handshake: req[i] is a level held until gnt[i]; gnt is a one-cycle,
// one-hot pulse coincident with rnd_valid, and rnd_out is valid only in
// that cycle. The requester drops req[i] before the following cycle; a
// req still high in the next IDLE cycle is treated as a fresh request.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   seed_load  : one-cycle pulse, loads seed_val (zero maps to SEED)
//   seed_val   : new seed
//   req        : per-requester request levels
//   gnt        : one-hot grant pulse
//   rnd_out    : reduced random word, (x % RANGE) + MIN_VALUE
//   rnd_valid  : rnd_out valid pulse
//   busy       : high while in STEP or OUT
module prng_share_ctrl
  import prng_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] SEED      = DEF_SEED,
  parameter int unsigned A         = DEF_A,
  parameter int unsigned B         = DEF_B,
  parameter int unsigned C         = DEF_C,
  parameter logic [31:0] RANGE     = DEF_RANGE,
  parameter logic [31:0] MIN_VALUE = DEF_MIN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [31:0]        seed_val,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [31:0]        rnd_out,
  output logic               rnd_valid,
  output logic               busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  prng_state_e       fsm_state;
  logic [31:0]       state_q;
  logic [31:0]       rnd_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic              valid_q;
  logic              busy_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  win_q;

  logic [PTR_W-1:0]  arb_win;
  logic              arb_any;
  logic [31:0]       next_x;
  logic [31:0]       seed_g;

  prng_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (arb_win),
    .any_req (arb_any)
  );

  assign next_x = xorshift32(state_q, A, B, C);
  // zero guard: the generator state must never become 0
  assign seed_g = (seed_val == 32'h0) ? SEED : seed_val;

  // The grant is registered on entry to OUT. A seed_load arriving in the
  // OUT cycle itself aborts the transaction, so the registered pulse is
  // masked by seed_load rather than waiting a cycle to retract it.
  assign gnt       = gnt_q & {NUM_REQ{~seed_load}};
  assign rnd_valid = valid_q & ~seed_load;
  assign rnd_out   = rnd_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= ST_IDLE;
      state_q   <= SEED;
      rnd_q     <= 32'h0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      win_q     <= '0;
    end else begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      case (fsm_state)
        ST_IDLE: begin
          if (seed_load) begin
            // seed wins over a simultaneous request; the request is
            // picked up in the next IDLE cycle from the new seed
            state_q <= seed_g;
          end else if (arb_any) begin
            win_q     <= arb_win;
            fsm_state <= ST_STEP;
            busy_q    <= 1'b1;
          end
        end
        ST_STEP: begin
          if (seed_load) begin
            state_q   <= seed_g;
            fsm_state <= ST_IDLE;
            busy_q    <= 1'b0;
          end else begin
            state_q   <= next_x;
            rnd_q     <= (next_x % RANGE) + MIN_VALUE;
            gnt_q     <= ONE << win_q;
            valid_q   <= 1'b1;
            fsm_state <= ST_OUT;
          end
        end
        ST_OUT: begin
          fsm_state <= ST_IDLE;
          busy_q    <= 1'b0;
          if (seed_load) begin
            // aborted: new seed replaces the advanced state and the
            // pointer stays so the same requester is served again
            state_q <= seed_g;
          end else begin
            ptr_q <= (win_q == LAST_IDX) ? '0 : win_q + PTR_W'(1);
          end
        end
        default: begin
          fsm_state <= ST_IDLE;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prng_share_ctrl.sv
module tb_prng_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [31:0] seed_val;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] rnd_out;
  logic        rnd_valid;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  logic [31:0] exp_q[$];
  logic [31:0] mstate;

  localparam logic [31:0] M_RANGE = 32'h0004_0001;

  prng_share_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .req       (req),
    .gnt       (gnt),
    .rnd_out   (rnd_out),
    .rnd_valid (rnd_valid),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // reference generator
  function automatic logic [31:0] m_xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x >> 13);
    y = y ^ (y << 17);
    y = y ^ (y >> 5);
    return y;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // waits (bounded) for a grant; returns the number of negedges taken
  task automatic wait_gnt(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'h0 && n < max_cyc);
  endtask

  initial begin
    rst_n = 1'b0; seed_load = 1'b0; seed_val = 32'h0; req = 4'h0;
    @(negedge clk);
    check("rst_gnt",   {28'h0, gnt}, 32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", {31'h0, rnd_valid}, 32'h0);
    check("idle_rnd",   rnd_out, 32'h0);

    // T1: single request, latency and busy window
    req = 4'b0001;
    @(negedge clk);
    check("t1_step_busy", {31'h0, busy}, 32'h1);
    check("t1_step_gnt",  {28'h0, gnt}, 32'h0);
    @(negedge clk);
    check("t1_gnt",   {28'h0, gnt}, 32'h1);
    check("t1_valid", {31'h0, rnd_valid}, 32'h1);
    check("t1_rnd",   rnd_out, 32'h0002_1EE6);
    check("t1_busy",  {31'h0, busy}, 32'h1);
    req = 4'b0000;
    @(negedge clk);
    check("t1_busy_off", {31'h0, busy}, 32'h0);
    check("t1_valid_off", {31'h0, rnd_valid}, 32'h0);
    check("t1_rnd_hold", rnd_out, 32'h0002_1EE6);

    // T2: all four requesting from pointer 0
    do_reset();
    mstate = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      mstate = m_xs(mstate);
      exp_q.push_back(mstate % M_RANGE);
    end
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(8, cyc);
      check($sformatf("t2_gnt%0d", k), {28'h0, gnt}, 32'h1 << k);
      check($sformatf("t2_lat%0d", k), 32'(cyc), (k == 0) ? 32'd2 : 32'd3);
      check($sformatf("t2_rnd%0d", k), rnd_out, exp_q.pop_front());
      req = req & ~gnt;
    end

    // T3: zero seed maps to the default seed
    @(negedge clk);
    seed_val = 32'h0; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; req = 4'b0100;
    wait_gnt(8, cyc);
    check("t3_gnt", {28'h0, gnt}, 32'h4);
    check("t3_rnd", rnd_out, 32'h0002_1EE6);
    req = 4'b0000;

    // T4: seed_load in STEP aborts; requester re-served from new seed
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    seed_val = 32'h1234_5678; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("t4_abort_gnt",   {28'h0, gnt}, 32'h0);
    check("t4_abort_valid", {31'h0, rnd_valid}, 32'h0);
    check("t4_abort_busy",  {31'h0, busy}, 32'h0);
    wait_gnt(8, cyc);
    check("t4_gnt", {28'h0, gnt}, 32'h4);
    check("t4_lat", 32'(cyc), 32'd2);
    check("t4_rnd", rnd_out, m_xs(32'h1234_5678) % M_RANGE);
    req = 4'b0000;

    // T5: seed_load in OUT masks the grant; pointer (3) stays put
    @(negedge clk);
    req = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    check("t5_pre_gnt", {28'h0, gnt}, 32'h1);
    seed_val = 32'h0BAD_F00D; seed_load = 1'b1;
    #1;
    check("t5_mask_gnt",   {28'h0, gnt}, 32'h0);
    check("t5_mask_valid", {31'h0, rnd_valid}, 32'h0);
    @(negedge clk);
    seed_load = 1'b0;
    wait_gnt(8, cyc);
    mstate = m_xs(32'h0BAD_F00D);
    check("t5_regnt", {28'h0, gnt}, 32'h1);
    check("t5_rnd0",  rnd_out, mstate % M_RANGE);
    req = req & ~gnt;
    wait_gnt(8, cyc);
    mstate = m_xs(mstate);
    check("t5_gnt1", {28'h0, gnt}, 32'h2);
    check("t5_lat1", 32'(cyc), 32'd3);
    check("t5_rnd1", rnd_out, mstate % M_RANGE);
    req = 4'b0000;

    // T6: asynchronous reset during OUT
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    check("t6_pre_gnt", {28'h0, gnt}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_gnt",   {28'h0, gnt}, 32'h0);
    check("t6_rst_valid", {31'h0, rnd_valid}, 32'h0);
    check("t6_rst_rnd",   rnd_out, 32'h0);
    check("t6_rst_busy",  {31'h0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(8, cyc);
    check("t6_gnt", {28'h0, gnt}, 32'h1);
    check("t6_rnd", rnd_out, 32'h0002_1EE6);
    req = 4'b0000;

    // T7: seed_load and req together in IDLE, seed of 1
    @(negedge clk);
    seed_val = 32'h1; seed_load = 1'b1; req = 4'b1000;
    @(negedge clk);
    seed_load = 1'b0;
    check("t7_seed_first", {31'h0, busy}, 32'h0);
    wait_gnt(8, cyc);
    check("t7_lat", 32'(cyc + 1), 32'd3);
    check("t7_gnt", {28'h0, gnt}, 32'h8);
    check("t7_rnd", rnd_out, 32'h0002_1001);
    req = 4'b0000;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
